// File: rtl/shiftreg_arbiter.sv
// -----------------------------------------------------------------------------
// shiftreg_arbiter
//
// Shares one 74HC595-style serial chain between two requesters. Each requester
// offers a WIDTH-bit word with valid/ready; a round-robin arbiter picks the
// winner while idle, the word is shifted out MSB first (shift_data stable
// across both halves of each shift_clock period), and shift_latch is then
// strobed for LATCH_CYCLES clocks.
//
// Optional feature (macro SHIFTREG_ARB_REFRESH_EN): the last accepted word is
// remembered and re-sent automatically after REFRESH_PERIOD consecutive idle
// cycles without an acceptance. A request in the expiry cycle wins instead.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   req0_valid/data/ready      requester 0 handshake (ready is combinational)
//   req1_valid/data/ready      requester 1 handshake (ready is combinational)
//   shift_clock/data/latch     serial chain pins (registered)
//   busy                       high whenever a word or latch pulse is in flight
//   last_grant                 index of the most recently accepted requester
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module shiftreg_arbiter #(
    parameter int WIDTH          = 8,     // bits per word, >= 2
    parameter int CLK_DIV        = 4,     // clk cycles per shift_clock half-period
    parameter int LATCH_CYCLES   = 2,     // clk cycles shift_latch stays high
    parameter int REFRESH_PERIOD = 1000   // idle cycles before automatic re-send
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             shift_clock,
    output logic             shift_data,
    output logic             shift_latch,
    output logic             busy,
    output logic             last_grant
);

    // One shared counter times both the shift half-periods and the latch pulse.
    localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;       // remaining bits, current bit at the MSB
    logic [BW-1:0]    bit_idx;    // index of the bit currently on shift_data
    logic [CW-1:0]    cnt;

    logic             idle;
    logic             grant;
    logic             accept;
    logic             start;
    logic             refresh_fire;
    logic [WIDTH-1:0] data_sel;
    logic [WIDTH-1:0] start_word;

    // -------------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE. With both requesting, the one that
    // did not win last time gets the chain.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned (which would infer a latch).
    always_comb begin
        idle  = (state == IDLE);
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = idle && req0_valid && !grant;
        req1_ready = idle && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;
        data_sel   = grant ? req1_data : req0_data;
    end

`ifdef SHIFTREG_ARB_REFRESH_EN
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_PERIOD - 1);

    logic [WIDTH-1:0] stored_word;
    logic [RW-1:0]    idle_cnt;

    // Fires on the REFRESH_PERIOD-th consecutive idle cycle; a real request in
    // the same cycle takes precedence.
    assign refresh_fire = idle && !accept && (idle_cnt == REFRESH_LAST);
    assign start_word   = accept ? data_sel : stored_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_word <= '0;
            idle_cnt    <= '0;
        end else begin
            if (accept) begin
                stored_word <= data_sel;
            end
            if (!idle || accept || refresh_fire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign refresh_fire = 1'b0;
    assign start_word   = data_sel;

    // The period only matters for the refresh build; keeping a reference here
    // lets an illegal value show up as a named scope in the elaborated design.
    if (REFRESH_PERIOD < 1) begin : g_refresh_period_invalid
    end
`endif

    assign start = accept || refresh_fire;

    // -------------------------------------------------------------------------
    // Serializer FSM. All chain pins and busy are registered here.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            shift_clock <= 1'b0;
            shift_data  <= 1'b0;
            shift_latch <= 1'b0;
            busy        <= 1'b0;
            last_grant  <= 1'b1;   // so requester 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SHIFT_LO;
                        sreg       <= start_word;
                        shift_data <= start_word[WIDTH-1];
                        bit_idx    <= BW'(WIDTH - 1);
                        cnt        <= '0;
                        busy       <= 1'b1;
                        // A refresh leaves the round-robin history alone.
                        if (accept) begin
                            last_grant <= grant;
                        end
                    end
                end

                SHIFT_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt         <= '0;
                        state       <= SHIFT_HI;
                        shift_clock <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHIFT_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt         <= '0;
                        shift_clock <= 1'b0;
                        if (bit_idx == '0) begin
                            state       <= LATCH;
                            shift_data  <= 1'b0;
                            shift_latch <= 1'b1;
                        end else begin
                            // Next bit goes out on the falling edge so it is
                            // settled a full half-period before the next rise.
                            state      <= SHIFT_LO;
                            bit_idx    <= bit_idx - 1'b1;
                            sreg       <= {sreg[WIDTH-2:0], 1'b0};
                            shift_data <= sreg[WIDTH-2];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        shift_latch <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_arbiter.sv
`timescale 1ns/1ps

module tb_shiftreg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: defaults, short refresh period for the optional build.
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       shift_clock, shift_data, shift_latch, busy, last_grant;

    // Second instance: 16-bit word, fastest shift clock, 1-cycle latch.
    logic        rst2_n;
    logic        b_req0_valid, b_req1_valid;
    logic [15:0] b_req0_data, b_req1_data;
    logic        b_req0_ready, b_req1_ready;
    logic        b_sclk, b_sdata, b_slatch, b_busy, b_last_grant;

    shiftreg_arbiter #(.WIDTH(8), .CLK_DIV(4), .LATCH_CYCLES(2), .REFRESH_PERIOD(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .shift_clock(shift_clock), .shift_data(shift_data), .shift_latch(shift_latch),
        .busy(busy), .last_grant(last_grant)
    );

    shiftreg_arbiter #(.WIDTH(16), .CLK_DIV(1), .LATCH_CYCLES(1), .REFRESH_PERIOD(100000)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .shift_clock(b_sclk), .shift_data(b_sdata), .shift_latch(b_slatch),
        .busy(b_busy), .last_grant(b_last_grant)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic       lg;       // model of last_grant for the main instance
    logic [1:0] pat;
    int         who;
    logic [7:0] w0, w1;
    logic [15:0] wb;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // {busy, shift_clock, shift_data, shift_latch, req0_ready, req1_ready}
    function automatic logic [5:0] obs(input int sel);
        if (sel == 0)
            return {busy, shift_clock, shift_data, shift_latch, req0_ready, req1_ready};
        return {b_busy, b_sclk, b_sdata, b_slatch, b_req0_ready, b_req1_ready};
    endfunction

    task automatic withdraw(input int sel, input int which);
        if (sel == 0) begin
            if (which == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end else begin
            if (which == 0) b_req0_valid = 1'b0; else b_req1_valid = 1'b0;
        end
    endtask

    // Reference waveform for one word, derived from the protocol rules:
    // first sample is the idle/accept cycle (who: 0/1 = that ready, 2 = refresh),
    // then for each bit MSB first CLK_DIV low-half and CLK_DIV high-half cycles
    // with the bit on shift_data, then LATCH_CYCLES of latch with data 0.
    task automatic xfer(input int sel, input logic [15:0] w, input int who,
                        input bit drop, input int raise_at);
        int wd, dv, lc, n;
        logic [5:0] e;
        wd = (sel == 0) ? 8 : 16;
        dv = (sel == 0) ? 4 : 1;
        lc = (sel == 0) ? 2 : 1;
        n  = 2 * dv * wd + lc;
        @(negedge clk);
        e = {4'b0000, who == 0, who == 1};
        check("accept_cycle", 16'(obs(sel)), 16'(e));
        if (drop && who < 2) begin
            @(posedge clk); #1;
            withdraw(sel, who);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < 2 * dv * wd)
                e = {1'b1, (k % (2 * dv)) >= dv, w[wd - 1 - k / (2 * dv)], 3'b000};
            else
                e = 6'b100100;
            check($sformatf("word_cycle_%0d", k), 16'(obs(sel)), 16'(e));
            if (k == raise_at) req0_valid = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = '0; b_req1_data = '0;
        lg = 1'b1;

        // ---- 16-bit / CLK_DIV=1 / LATCH=1 instance: 33 busy cycles -------------
        repeat (3) @(negedge clk);
        check("rst2_outputs", 16'(obs(1)), 16'h0);
        rst2_n = 1'b1;
        @(posedge clk); #1;
        wb = 16'($urandom);
        b_req0_valid = 1'b1; b_req0_data = wb;
        xfer(1, wb, 0, 1'b1, -1);
        @(negedge clk);
        check("w16_idle_after_33", 16'(obs(1)), 16'h0);
        check("w16_last_grant", 16'(b_last_grant), 16'h0);

        // ---- main instance reset state -----------------------------------------
        @(negedge clk);
        check("rst_outputs", 16'(obs(0)), 16'h0);
        check("rst_last_grant", 16'(last_grant), 16'h1);
        rst_n = 1'b1;

        // ---- single word 8'hA5 from req0 ---------------------------------------
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 8'hA5;
        xfer(0, 16'hA5, 0, 1'b1, -1);
        lg = 1'b0;
        check("a5_last_grant", 16'(last_grant), 16'(lg));

        // ---- both held: strict alternation, no dead cycle ----------------------
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 8'h0F;
        req1_valid = 1'b1; req1_data = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            who = (lg == 1'b1) ? 0 : 1;
            xfer(0, (who == 1) ? 16'hF0 : 16'h0F, who, 1'b0, -1);
            lg = (who == 1);
            check("held_last_grant", 16'(last_grant), 16'(lg));
        end

        // ---- req1 alone, req0 raised mid-transfer ------------------------------
        @(posedge clk); #1;
        w0 = 8'($urandom); w1 = 8'($urandom);
        req0_valid = 1'b0; req0_data = w0;
        req1_valid = 1'b1; req1_data = w1;
        xfer(0, 16'(w1), 1, 1'b1, 20);
        lg = 1'b1;
        xfer(0, 16'(w0), 0, 1'b1, -1);
        lg = 1'b0;
        check("mid_last_grant", 16'(last_grant), 16'(lg));

        // ---- randomized request patterns against the round-robin model ---------
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            pat = 2'($urandom_range(1, 3));
            w0 = 8'($urandom); w1 = 8'($urandom);
            req0_valid = pat[0]; req0_data = w0;
            req1_valid = pat[1]; req1_data = w1;
            if (pat == 2'b11) who = (lg == 1'b1) ? 0 : 1;
            else              who = pat[1] ? 1 : 0;
            xfer(0, (who == 1) ? 16'(w1) : 16'(w0), who, 1'b1, -1);
            lg = (who == 1);
            check("rand_last_grant", 16'(last_grant), 16'(lg));
        end

        // ---- reset during bit 3: immediate clear, no latch pulse ---------------
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hC3;
        @(negedge clk);
        check("rstmid_accept", 16'(obs(0)), 16'b000010);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (34) @(negedge clk);
        check("rstmid_busy_before", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #1;
        check("rstmid_outputs", 16'(obs(0)), 16'h0);
        check("rstmid_last_grant", 16'(last_grant), 16'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_no_latch", 16'(obs(0)), 16'h0);
        end
        rst_n = 1'b1;
        lg = 1'b1;

        // ---- clean transfer after reset (8'h3C, stored for refresh) ------------
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 8'h3C;
        xfer(0, 16'h3C, 0, 1'b1, -1);
        lg = 1'b0;
        check("post_rst_last_grant", 16'(last_grant), 16'(lg));

`ifdef SHIFTREG_ARB_REFRESH_EN
        // 19 quiet idle cycles, refresh starts from the 20th.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("refresh_wait_idle", 16'(obs(0)), 16'h0);
        end
        xfer(0, 16'h3C, 2, 1'b0, -1);
        check("refresh_last_grant", 16'(last_grant), 16'(lg));
        // Request lands exactly in the expiry cycle and wins.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("refresh_wait_idle2", 16'(obs(0)), 16'h0);
        end
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_data = 8'h5A;
        xfer(0, 16'h5A, 1, 1'b1, -1);
        lg = 1'b1;
        check("expiry_req_last_grant", 16'(last_grant), 16'(lg));
`else
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("no_refresh_idle", 16'(obs(0)), 16'h0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shiftreg_arbiter.md
Name: shiftreg_arbiter

Overview:
- Shares one serial shift-register chain (74HC595-style: shift_clock / shift_data / shift_latch) between two requesters.
- Each requester hands over a WIDTH-bit word with a valid/ready handshake. A round-robin arbiter picks a winner, and the serializer shifts the word out MSB first, then pulses the latch.
- Sits between LED/pattern logic in top and the shift_* pins.

Parameters:
- WIDTH, 8, bits per word / chain length.
- CLK_DIV, 4, clk cycles per shift_clock half-period (>=1).
- LATCH_CYCLES, 2, clk cycles shift_latch is held high (>=1).
- REFRESH_PERIOD, 1000, idle clk cycles before automatic re-send (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- shift_clock  output  1  serial clock to chain.
- shift_data  output  1  serial data to chain.
- shift_latch  output  1  storage-register latch strobe.
- busy  output  1  high whenever state != IDLE.
- last_grant  output  1  index of the most recently accepted requester.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - state=IDLE; shift_clock=0, shift_data=0, shift_latch=0, busy=0.
  - last_grant=1, so req0 wins the first tie.
  - Shift register and bit/div counters cleared.
  - A reset mid-transfer aborts it; the latch is not pulsed and no partial word is latched.
- States:
  - IDLE: wait for a request.
  - SHIFT_LO: shift_clock=0, shift_data=current bit; CLK_DIV cycles.
  - SHIFT_HI: shift_clock=1, data unchanged; CLK_DIV cycles.
  - LATCH: shift_clock=0, shift_latch=1; LATCH_CYCLES cycles.
- Arbitration:
  - Combinational, only in IDLE: reqN_ready = (state==IDLE) && grant==N && reqN_valid.
  - One valid: it wins. Both valid: the one != last_grant wins.
  - At most one ready high per cycle.
- Transfer:
  - On the edge where valid&&ready, capture data, update last_grant, and go to SHIFT_LO with bit index WIDTH-1.
  - shift_data is updated on the entry edge to SHIFT_LO and is stable through the whole bit (both halves).
  - After SHIFT_HI of bit 0, go to LATCH, then IDLE.
- Timing:
  - busy=1 for exactly 2*CLK_DIV*WIDTH + LATCH_CYCLES cycles per word (66 with defaults).
  - A new acceptance is possible in the first IDLE cycle afterwards, so there is no dead cycle beyond IDLE itself.
- Held requests:
  - Requests arriving while busy are held by the requester (valid stays high, data stable); no queueing inside.
  - Dropping valid before ready is legal and simply withdraws the request.
- shift_data returns to 0 in LATCH and IDLE.
- All outputs are registered except reqN_ready.

Optional Feature:
- Macro: SHIFTREG_ARB_REFRESH_EN.
- Defined:
  - The last accepted word is kept in a WIDTH-bit register (reset 0).
  - An idle counter counts consecutive IDLE cycles without acceptance. When it reaches REFRESH_PERIOD, the block re-sends the stored word (same sequence, no ready asserted) and the counter clears.
  - A request valid in the same cycle the counter expires takes priority; the refresh is skipped and the counter clears.
  - last_grant is unchanged by a refresh.
- Undefined: no storage, no counter; the block only shifts on request.

Test Plan:
- Reset, then req0_valid=1, data=8'hA5 -> req0_ready pulses 1 cycle. shift_data per bit = 1,0,1,0,0,1,0,1. Each shift_clock rising edge is 4 cycles after the bit is set. shift_latch is high 2 cycles after the 8th fall. busy high for 66 cycles.
- req0 and req1 both held valid (8'h0F, 8'hF0) -> order 0,1,0,1…; last_grant toggles each word. Neither ready is high while busy.
- req1 only, with req0 asserted mid-transfer -> req1 word completes untouched. req0 is accepted in the first IDLE cycle after LATCH.
- rst_n pulled low at bit 3 of a transfer -> all outputs 0 immediately (async), no latch pulse. After release, a new request shifts cleanly.
- Refresh with macro defined, REFRESH_PERIOD=20: send 8'h3C, then no requests -> 8'h3C re-sent 20 idle cycles after return to IDLE, with no ready pulse. A request in the expiry cycle is sent instead of the refresh. With macro undefined -> no re-send.
- CLK_DIV=1, LATCH_CYCLES=1, WIDTH=16 -> busy exactly 33 cycles; shift_clock period 2 cycles.
